fc_argmax: RTL and testbench
============================

// Module: fc_argmax
// PURPOSE
//   Streaming argmax stage directly downstream of the FC datapath. Consumes FC output
//   words (4 packed signed 8-bit results per 32-bit word), tracks the running maximum
//   and its element index, and on completion presents max_index/max_value plus a
//   one-cycle done pulse. The done pulse is the FC_DONE source for the APB block.
// PARAMETERS
//   DATA_WIDTH  32  input word width; must equal LANES*ELEM_WIDTH
//   ELEM_WIDTH  8   width of one signed FC result
//   LANES       4   results per input word; lane 0 = bits[7:0] = lowest element index
//   SIZE_WIDTH  21  width of the element-count input
// PORTS
//   clk        in   1           clock; all state on rising edge
//   rstn       in   1           asynchronous active-low reset
//   start      in   1           1-cycle pulse; samples size and begins a run (accepted only in IDLE)
//   size       in   SIZE_WIDTH  number of valid elements in the run
//   in_valid   in   1           input word valid
//   in_data    in   DATA_WIDTH  packed signed results
//   in_ready   out  1           1 only in RUN; word transfers when in_valid & in_ready
//   busy       out  1           1 in RUN or DONE
//   done       out  1           1-cycle pulse at end of run
//   max_index  out  32          index of the maximum element (zero-extended)
//   max_value  out  ELEM_WIDTH  signed maximum value
// BEHAVIOUR
//   Reset (rstn=0, async): state=IDLE; in_ready=0, busy=0, done=0, max_index=0,
//     max_value=-2^(ELEM_WIDTH-1) (8'h80); internal counters cleared.
//   FSM: IDLE --start & size!=0--> RUN; IDLE --start & size==0--> DONE;
//     RUN --last element accepted--> DONE; DONE --(always, 1 cycle)--> IDLE.
//   On start: latch size; elem_cnt=0; max_value=8'h80; max_index=0; first_seen=0.
//   RUN, per accepted word: lanes j=0..LANES-1 with elem_cnt+j < size_latched are
//     valid; lanes beyond size are ignored. Word winner = highest value among valid
//     lanes, lowest lane on ties. Update running max iff !first_seen or winner value
//     > max_value (strict, signed). Result: first occurrence wins ties globally.
//     first_seen set after first word; elem_cnt += LANES.
//   Last element: accepted word where elem_cnt+LANES >= size_latched. State goes to DONE
//     on that edge; in_ready drops the following cycle (no further words accepted).
//   Latency: done=1 exactly one cycle after the clock edge accepting the last word;
//     max_index/max_value already final in that cycle and held stable until next start.
//   size==0: done pulses the cycle after start; max_index=0, max_value=8'h80.
//   start while busy: ignored (no relatch, no restart). start and done never overlap
//     effect: start in the DONE cycle is ignored.
//   in_valid low in RUN: stall, no state change; no timeout.
//   Arithmetic: all compares signed ELEM_WIDTH; elem_cnt SIZE_WIDTH+2 bits, cannot wrap
//     for size <= 2^SIZE_WIDTH-1. max_index = elem_cnt + winning lane.
//   Reset mid-run: immediate return to IDLE with reset values; no done pulse emitted.
//   busy = (state != IDLE); done = (state == DONE).
// TESTING
//   T1 size=8, words 32'h04_03_02_01, 32'h05_7F_06_00 -> done 1 cycle after word 2,
//      max_index=6, max_value=8'h7F.
//   T2 size=4, word 32'h80_FF_FE_FD (all negative) -> max_index=2, max_value=8'hFF.
//   T3 size=6, tie: words 32'h10_20_20_00, 32'h20_20_05_01 -> max_index=1 (first occurrence).
//   T4 size=5, words 32'h00_00_00_01, 32'h7F_7F_7F_02 -> lanes 1..3 of word 2 ignored,
//      max_index=4, max_value=8'h02; in_ready=0 the cycle after word 2.
//   T5 size=0 start -> done next cycle, max_index=0, max_value=8'h80, in_ready never 1;
//      then start during RUN of a size=8 run -> ignored, result as T1.
//   T6 rstn low after 1 of 2 words, random in_valid gaps elsewhere -> all outputs at reset
//      values, no done; fresh run afterwards matches T1.

Source files
------------

// File: rtl/fc_argmax_if.sv
// ---------------------------------------------------------------------------
// fc_argmax_if
//   Bundles the control, stream and result signals of the FC argmax stage.
//
//   Signals
//     start      1-cycle run request; size is sampled with it
//     size       number of valid elements in the run
//     in_valid   input word valid
//     in_data    LANES packed signed results, lane 0 in the low bits
//     in_ready   stage can accept a word this cycle
//     busy       a run is in progress or its done cycle is being presented
//     done       1-cycle completion pulse (FC_DONE source for the APB block)
//     max_index  element index of the maximum, zero-extended to 32 bits
//     max_value  signed maximum value
//
//   Modports
//     master  drives start/size/in_valid/in_data, observes the rest
//     slave   the argmax stage itself
// ---------------------------------------------------------------------------
interface fc_argmax_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ELEM_WIDTH = 8,
    parameter int SIZE_WIDTH = 21
);
    logic                  start;
    logic [SIZE_WIDTH-1:0] size;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  busy;
    logic                  done;
    logic [31:0]           max_index;
    logic [ELEM_WIDTH-1:0] max_value;

    modport master (
        output start, size, in_valid, in_data,
        input  in_ready, busy, done, max_index, max_value
    );

    modport slave (
        input  start, size, in_valid, in_data,
        output in_ready, busy, done, max_index, max_value
    );
endinterface

// File: rtl/fc_argmax.sv
// ---------------------------------------------------------------------------
// fc_argmax
//   Streaming argmax stage sitting directly after the FC datapath. Each input
//   word carries LANES signed ELEM_WIDTH-bit results. The stage tracks the
//   running maximum and the index of its first occurrence, and when the last
//   element of the run has been accepted it presents max_index/max_value
//   together with a one-cycle done pulse.
//
//   Ports
//     clk    clock, all state changes on the rising edge
//     rstn   asynchronous active-low reset
//     bus    fc_argmax_if.slave (start/size, in_valid/in_data/in_ready,
//            busy/done, max_index/max_value)
//
//   Parameters
//     DATA_WIDTH  input word width, must equal LANES*ELEM_WIDTH
//     ELEM_WIDTH  width of one signed FC result
//     LANES       results per word; lane 0 holds the lowest element index
//     SIZE_WIDTH  width of the element-count input
// ---------------------------------------------------------------------------
module fc_argmax #(
    parameter int DATA_WIDTH = 32,
    parameter int ELEM_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int SIZE_WIDTH = 21
) (
    input  logic        clk,
    input  logic        rstn,
    fc_argmax_if.slave  bus
);

    // Two spare bits so elem_cnt + LANES never wraps for any legal size.
    localparam int CNT_W  = SIZE_WIDTH + 2;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    // Most negative ELEM_WIDTH value: the "nothing seen yet" maximum.
    localparam logic [ELEM_WIDTH-1:0] MIN_VAL = {1'b1, {(ELEM_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                        state_q;
    logic [SIZE_WIDTH-1:0]         size_q;
    logic [CNT_W-1:0]              elem_cnt_q;
    logic                          first_seen_q;
    logic signed [ELEM_WIDTH-1:0]  max_value_q;
    logic [31:0]                   max_index_q;
    logic                          in_ready_q;
    logic                          busy_q;
    logic                          done_q;

    // -----------------------------------------------------------------------
    // Lane unpacking and per-lane validity
    //   A lane is valid when its element index is still below the latched
    //   size; lanes of the final, partially filled word are ignored.
    // -----------------------------------------------------------------------
    logic signed [ELEM_WIDTH-1:0]  lane_val [LANES];
    logic [LANES-1:0]              lane_vld;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_val[gi] = bus.in_data[gi*ELEM_WIDTH +: ELEM_WIDTH];
            assign lane_vld[gi] = (elem_cnt_q + CNT_W'(gi)) < CNT_W'(size_q);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Word winner: highest valid lane value. Strict '>' while scanning
    // upward keeps the lowest lane on ties, which together with the strict
    // compare against the running max gives first-occurrence semantics.
    // -----------------------------------------------------------------------
    logic signed [ELEM_WIDTH-1:0]  win_val;
    logic [LANE_W-1:0]             win_lane;
    logic                          win_any;

    always_comb begin
        win_val  = lane_val[0];
        win_lane = '0;
        win_any  = lane_vld[0];
        for (int j = 1; j < LANES; j++) begin
            if (lane_vld[j] && (!win_any || (lane_val[j] > win_val))) begin
                win_val  = lane_val[j];
                win_lane = LANE_W'(j);
                win_any  = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Transfer qualification
    // -----------------------------------------------------------------------
    logic        take;
    logic        last_word;
    logic        take_max;
    logic [31:0] win_index;

    assign take      = (state_q == ST_RUN) && bus.in_valid;
    assign last_word = (elem_cnt_q + CNT_W'(LANES)) >= CNT_W'(size_q);
    assign take_max  = take && win_any && (!first_seen_q || (win_val > max_value_q));
    assign win_index = 32'(elem_cnt_q) + 32'(win_lane);

    // -----------------------------------------------------------------------
    // FSM with registered outputs. in_ready/busy/done are updated together
    // with the state so they always equal the decode of the state register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            size_q       <= '0;
            elem_cnt_q   <= '0;
            first_seen_q <= 1'b0;
            max_value_q  <= MIN_VAL;
            max_index_q  <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        size_q       <= bus.size;
                        elem_cnt_q   <= '0;
                        first_seen_q <= 1'b0;
                        max_value_q  <= MIN_VAL;
                        max_index_q  <= '0;
                        busy_q       <= 1'b1;
                        if (bus.size == '0) begin
                            // Empty run: report the reset result right away.
                            state_q    <= ST_DONE;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q    <= ST_RUN;
                            in_ready_q <= 1'b1;
                            done_q     <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    // start is ignored here; in_valid low simply stalls.
                    if (take) begin
                        if (take_max) begin
                            max_value_q <= win_val;
                            max_index_q <= win_index;
                        end
                        first_seen_q <= 1'b1;
                        elem_cnt_q   <= elem_cnt_q + CNT_W'(LANES);
                        if (last_word) begin
                            state_q    <= ST_DONE;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    // Single-cycle pulse; a start seen here is dropped.
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end

                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.max_index = max_index_q;
    assign bus.max_value = max_value_q;

`ifndef SYNTHESIS
    // Flag registers must track the state decode exactly.
    a_busy_decode: assert property (@(posedge clk) disable iff (!rstn)
        busy_q == (state_q != ST_IDLE));
    a_ready_decode: assert property (@(posedge clk) disable iff (!rstn)
        in_ready_q == (state_q == ST_RUN));
    a_done_decode: assert property (@(posedge clk) disable iff (!rstn)
        done_q == (state_q == ST_DONE));
    a_done_pulse: assert property (@(posedge clk) disable iff (!rstn)
        done_q |=> !done_q);
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// ---------------------------------------------------------------------------
// tb_fc_argmax
//   Directed bench for fc_argmax with hand-computed expected results.
// ---------------------------------------------------------------------------
module tb_fc_argmax;

    logic clk;
    logic rstn;

    fc_argmax_if #(.DATA_WIDTH(32), .ELEM_WIDTH(8), .SIZE_WIDTH(21)) bus ();

    fc_argmax #(
        .DATA_WIDTH(32),
        .ELEM_WIDTH(8),
        .LANES     (4),
        .SIZE_WIDTH(21)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int ready_cnt = 0;

    // Observers, sampled on the inactive edge.
    always @(negedge clk) begin
        if (bus.done === 1'b1)     done_cnt++;
        if (bus.in_ready === 1'b1) ready_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [20:0] sz);
        bus.start = 1'b1;
        bus.size  = sz;
        tick();
        bus.start = 1'b0;
    endtask

    // Present one word and wait (bounded) until it is taken.
    task automatic send_word(input string tag, input logic [31:0] w);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) begin
            check({tag, " ready_timeout"}, 32'd0, 32'd1);
        end else begin
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
    endtask

    task automatic idle_gap(input bit gaps);
        int n;
        n = gaps ? int'($urandom_range(0, 3)) : 0;
        repeat (n) tick();
    endtask

    // Full run of up to two words with result and timing checks.
    task automatic run(input string tag, input logic [20:0] sz, input int nwords,
                       input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] exp_idx, input logic [7:0] exp_val,
                       input bit gaps);
        int d0;
        start_run(sz);
        check({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
        check({tag, " ready_after_start"}, 32'(bus.in_ready), 32'd1);
        idle_gap(gaps);
        d0 = done_cnt;
        send_word(tag, w0);
        if (nwords > 1) begin
            check({tag, " no_done_mid"}, 32'(bus.done), 32'd0);
            idle_gap(gaps);
            check({tag, " no_done_gap"}, 32'(done_cnt - d0), 32'd0);
            send_word(tag, w1);
        end
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " ready_dropped"}, 32'(bus.in_ready), 32'd0);
        check({tag, " max_index"}, bus.max_index, exp_idx);
        check({tag, " max_value"}, 32'(bus.max_value), 32'(exp_val));
        tick();
        check({tag, " done_pulse_end"}, 32'(bus.done), 32'd0);
        check({tag, " idle"}, 32'(bus.busy), 32'd0);
        check({tag, " index_held"}, bus.max_index, exp_idx);
        check({tag, " value_held"}, 32'(bus.max_value), 32'(exp_val));
        $display("%s size=%0d idx=%0d val=%02h", tag, sz, bus.max_index, bus.max_value);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int d0;
        int r0;
        rstn         = 1'b0;
        bus.start    = 1'b0;
        bus.size     = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) tick();

        // Reset state
        check("rst in_ready", 32'(bus.in_ready), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst max_index", bus.max_index, 32'd0);
        check("rst max_value", 32'(bus.max_value), 32'h80);
        rstn = 1'b1;
        repeat (2) tick();
        $display("reset released");

        // T1..T4
        run("T1", 21'd8, 2, 32'h04_03_02_01, 32'h05_7F_06_00, 32'd6, 8'h7F, 1'b0);
        run("T2", 21'd4, 1, 32'h80_FF_FE_FD, 32'h0, 32'd2, 8'hFF, 1'b0);
        run("T3", 21'd6, 2, 32'h10_20_20_00, 32'h20_20_05_01, 32'd1, 8'h20, 1'b0);
        run("T4", 21'd5, 2, 32'h00_00_00_01, 32'h7F_7F_7F_02, 32'd4, 8'h02, 1'b0);

        // T5a: empty run
        r0 = ready_cnt;
        d0 = done_cnt;
        start_run(21'd0);
        check("T5 zero done", 32'(bus.done), 32'd1);
        check("T5 zero max_index", bus.max_index, 32'd0);
        check("T5 zero max_value", 32'(bus.max_value), 32'h80);
        tick();
        check("T5 zero done_end", 32'(bus.done), 32'd0);
        check("T5 zero idle", 32'(bus.busy), 32'd0);
        check("T5 zero ready_never", 32'(ready_cnt - r0), 32'd0);
        check("T5 zero one_pulse", 32'(done_cnt - d0), 32'd1);
        $display("T5 size=0 idx=%0d val=%02h", bus.max_index, bus.max_value);

        // T5b: start during RUN must be ignored
        start_run(21'd8);
        send_word("T5b", 32'h04_03_02_01);
        start_run(21'd4);
        check("T5b still_run", 32'(bus.in_ready), 32'd1);
        check("T5b no_done", 32'(bus.done), 32'd0);
        send_word("T5b", 32'h05_7F_06_00);
        check("T5b done", 32'(bus.done), 32'd1);
        check("T5b max_index", bus.max_index, 32'd6);
        check("T5b max_value", 32'(bus.max_value), 32'h7F);
        // start in the DONE cycle must be ignored
        start_run(21'd8);
        check("T5c start_in_done_ignored", 32'(bus.busy), 32'd0);
        check("T5c index_held", bus.max_index, 32'd6);
        $display("T5b restart-ignored idx=%0d val=%02h", bus.max_index, bus.max_value);

        // T6: reset in the middle of a run
        d0 = done_cnt;
        start_run(21'd8);
        send_word("T6", 32'h04_03_02_01);
        rstn = 1'b0;
        #1;
        check("T6 rst in_ready", 32'(bus.in_ready), 32'd0);
        check("T6 rst busy", 32'(bus.busy), 32'd0);
        check("T6 rst done", 32'(bus.done), 32'd0);
        check("T6 rst max_index", bus.max_index, 32'd0);
        check("T6 rst max_value", 32'(bus.max_value), 32'h80);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (2) tick();
        check("T6 no_done", 32'(done_cnt - d0), 32'd0);
        $display("T6 mid-run reset, outputs at reset values");
        run("T6 fresh", 21'd8, 2, 32'h04_03_02_01, 32'h05_7F_06_00, 32'd6, 8'h7F, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
